// File: rtl/script_sequencer_pkg.sv
// Shared encodings for the script sequencer: opcodes, condition selects,
// feedback bit positions, instruction fields and FSM state codes.
package script_sequencer_pkg;

  localparam logic [2:0] OP_ACTION = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_WAIT   = 3'b011;
  localparam logic [2:0] OP_HALT   = 3'b111;

  localparam logic [1:0] FUNC_IF  = 2'b00;
  localparam logic [1:0] FUNC_IFN = 2'b01;

  localparam logic [1:0] PLAYER_READY   = 2'd0;
  localparam logic [1:0] PLAYER_HASITEM = 2'd1;
  localparam logic [1:0] TARGET_READY   = 2'd2;
  localparam logic [1:0] TARGET_HASITEM = 2'd3;

  localparam int unsigned FB_PLAYER_READY   = 2;
  localparam int unsigned FB_PLAYER_HASITEM = 3;
  localparam int unsigned FB_TARGET_READY   = 4;
  localparam int unsigned FB_TARGET_HASITEM = 5;

  localparam int unsigned F_NUM_LSB  = 8;
  localparam int unsigned F_SIGN_LSB = 5;
  localparam int unsigned F_FUNC_LSB = 3;
  localparam int unsigned F_OP_LSB   = 0;

  typedef struct packed {
    logic [7:0] num;
    logic [2:0] sign;
    logic [1:0] func;
    logic [2:0] op;
  } instr_t;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_DECODE = 3'd2;
  localparam state_t ST_ACT    = 3'd3;
  localparam state_t ST_WAIT   = 3'd4;
  localparam state_t ST_HALT   = 3'd5;

endpackage

// File: rtl/script_sequencer_if.sv
// Action handshake between the script sequencer and the game interface.
interface script_sequencer_if;
  logic       act_valid;
  logic       act_ready;
  logic [1:0] act_type;
  logic [7:0] act_arg;

  modport master (output act_valid, output act_type, output act_arg, input act_ready);
  modport slave  (input act_valid, input act_type, input act_arg, output act_ready);
endinterface

// File: rtl/script_sequencer_cond.sv
// Condition evaluator shared by jump and wait: selects a kitchen feedback bit
// and applies the func polarity.
module script_cond
  import script_sequencer_pkg::*;
(
  input  logic [7:0] feedback_sig,
  input  logic [2:0] i_sign,
  input  logic [1:0] func,
  output logic       cond
);

  logic sig;
  logic unused_fb;

  assign unused_fb = ^{feedback_sig[7:6], feedback_sig[1:0]};

  always_comb begin
    sig = 1'b0;
    if (!i_sign[2]) begin
      unique case (i_sign[1:0])
        PLAYER_READY:   sig = feedback_sig[FB_PLAYER_READY];
        PLAYER_HASITEM: sig = feedback_sig[FB_PLAYER_HASITEM];
        TARGET_READY:   sig = feedback_sig[FB_TARGET_READY];
        TARGET_HASITEM: sig = feedback_sig[FB_TARGET_HASITEM];
        default:        sig = 1'b0;
      endcase
    end
  end

  always_comb begin
    cond = 1'b0;
    case (func)
      FUNC_IF:  cond = sig;
      FUNC_IFN: cond = ~sig;
      default:  cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/script_sequencer.sv
// Script sequencer: fetches 16-bit instructions from synchronous ROM and issues
// actions, conditional jumps and bounded waits against kitchen feedback.
module script_sequencer
  import script_sequencer_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [7:0]         instr_addr,
  input  logic [15:0]        instr_data,
  input  logic [7:0]         feedback_sig,
  script_sequencer_if.master act,
  output logic [7:0]         pc,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  localparam int unsigned CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_LIMIT - 1);

  state_t      state;
  instr_t      cur;
  logic [2:0]  ir_sign;
  logic [1:0]  ir_func;
  logic [CW-1:0] wait_cnt;
  logic        act_valid_q;
  logic [1:0]  act_type_q;
  logic [7:0]  act_arg_q;
  logic [2:0]  cond_sign;
  logic [1:0]  cond_func;
  logic        cond;
  logic [7:0]  pc_step;
  logic [7:0]  pc_jump;

  // ROM data is valid during DECODE, so decode reads it live; WAIT keeps its
  // own copy of the condition fields.
  assign cur        = instr_t'(instr_data);
  assign instr_addr = pc;
  assign pc_step    = pc + 8'd2;
  assign pc_jump    = pc + {cur.num[6:0], 1'b0};
  assign cond_sign  = (state == ST_WAIT) ? ir_sign : cur.sign;
  assign cond_func  = (state == ST_WAIT) ? ir_func : cur.func;

  assign act.act_valid = act_valid_q;
  assign act.act_type  = act_type_q;
  assign act.act_arg   = act_arg_q;

  script_cond u_cond (
    .feedback_sig (feedback_sig),
    .i_sign       (cond_sign),
    .func         (cond_func),
    .cond         (cond)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= '0;
      ir_sign     <= '0;
      ir_func     <= '0;
      wait_cnt    <= '0;
      act_valid_q <= 1'b0;
      act_type_q  <= '0;
      act_arg_q   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state   <= ST_FETCH;
            pc      <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            timeout <= 1'b0;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          ir_sign <= cur.sign;
          ir_func <= cur.func;
          case (cur.op)
            OP_ACTION: begin
              state       <= ST_ACT;
              act_valid_q <= 1'b1;
              act_type_q  <= cur.func;
              act_arg_q   <= cur.num;
            end
            OP_JUMP: begin
              state <= ST_FETCH;
              pc    <= cond ? pc_jump : pc_step;
            end
            OP_WAIT: begin
              state    <= ST_WAIT;
              wait_cnt <= '0;
            end
            OP_HALT: begin
              state <= ST_HALT;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
            default: begin
              state <= ST_FETCH;
              pc    <= pc_step;
            end
          endcase
        end
        ST_ACT: begin
          if (act.act_ready) begin
            act_valid_q <= 1'b0;
            pc          <= pc_step;
            state       <= ST_FETCH;
          end
        end
        ST_WAIT: begin
          // A true condition on the final count is a normal exit.
          if (cond) begin
            pc    <= pc_step;
            state <= ST_FETCH;
          end else if (wait_cnt == CNT_LAST) begin
            timeout <= 1'b1;
            pc      <= pc_step;
            state   <= ST_FETCH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
